forward_ctrl: RTL and testbench
===============================

FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 Parameter: REG_W, 5, register-index width.
REQ-002 Parameter: ZERO_REG, 31, hard-wired zero register index; never forwarded, never causes stall.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 id_valid  input  1  decode-stage instruction present.
REQ-006 id_rn  input  REG_W  first source register (operand A).
REQ-007 id_rm  input  REG_W  second source register (operand B).
REQ-008 id_rd  input  REG_W  destination register.
REQ-009 id_regwrite  input  1  instruction writes id_rd.
REQ-010 id_memread  input  1  instruction is a load.
REQ-011 flush  input  1  taken branch; kill the decode-stage instruction.
REQ-012 a_sel1, b_sel1  output  1 each  1 = use forwarded data for the operand, 0 = use register-file data.
REQ-013 a_sel0, b_sel0  output  1 each  valid only when the matching sel1 = 1; 1 = EX result, 0 = MEM/load data.
REQ-014 stall  output  1  hold PC and decode register for one cycle and insert a bubble.
REQ-015 stall_count  output  32  number of stall cycles; present only with FWD_PERF_CNT_EN.

Function
REQ-016 Two internal tracking entries, EX and MEM, each holding valid, rd, regwrite and memread.
REQ-017 Each clock, if stall = 0, id_valid = 1 and flush = 0, the EX entry SHALL load the id_* fields; otherwise the EX entry SHALL load a bubble (valid = 0).
REQ-018 Each clock, the MEM entry SHALL load the EX entry unconditionally.
REQ-019 An entry SHALL match a source register only when valid, regwrite and the source equals rd and rd != ZERO_REG.
REQ-020 Operand X (A uses id_rn, B uses id_rm) on an EX match: X_sel1 = 1 and X_sel0 = 1.
REQ-021 Operand X on a MEM match with no EX match: X_sel1 = 1 and X_sel0 = 0.
REQ-022 Operand X with no match: X_sel1 = 0 and X_sel0 = 0.
REQ-023 When EX and MEM both match, EX SHALL win (youngest producer).
REQ-024 Select outputs SHALL be combinational from the current id_* inputs and the registered entries, with zero-cycle latency; they SHALL be 0 when id_valid = 0.
REQ-025 stall = id_valid & !flush & EX.valid & EX.memread & EX.regwrite & EX.rd != ZERO_REG & (id_rn == EX.rd | id_rm == EX.rd).
REQ-026 A stall SHALL last exactly one cycle per load-use pair.
- The next cycle the load sits in MEM, so stall deasserts.
- The held instruction then forwards with sel1 = 1 and sel0 = 0.
REQ-027 When flush and a load-use condition occur together, flush SHALL win: stall = 0 and a bubble enters EX.
REQ-028 Both operands hitting the same producer SHALL set both selects identically.

Reset
REQ-029 While reset is high, both entries SHALL be cleared to valid = 0 and rd = 0, and stall_count SHALL be cleared to 0.
REQ-030 While reset is high, stall and all sel outputs SHALL read 0 regardless of the id_* inputs.
REQ-031 Reset asserted mid-stall SHALL drop stall in the same cycle; there SHALL be no residual stall after release.

Configuration
REQ-032 Macro FWD_PERF_CNT_EN, when defined:
- The stall_count port SHALL exist.
- stall_count SHALL increment by 1 on each clock edge where stall = 1.
- stall_count SHALL saturate at 32'hFFFFFFFF.
REQ-033 When FWD_PERF_CNT_EN is undefined, the port and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 ADD X1 followed by SUB using rn = 1, rm = 2 -> second cycle a_sel1 = 1, a_sel0 = 1, b_sel1 = 0, stall = 0.
REQ-035 ADD X3, then NOP, then ORR using rm = 3 -> b_sel1 = 1, b_sel0 = 0.
REQ-036 LDUR X5 followed by ADD using rn = 5 -> stall = 1 for exactly one cycle, then a_sel1 = 1, a_sel0 = 0; stall_count = 1 (macro on).
REQ-037 Producer rd = 31 followed by consumer rn = 31 -> all selects 0, stall = 0; load to X31 followed by use of X31 -> no stall.
REQ-038 ADD X4, then ADD X4, then consumer rn = 4 -> a_sel0 = 1 (EX priority); load-use with flush = 1 in the same cycle -> stall = 0.
REQ-039 Reset pulse asserted during a stall -> stall, all selects and stall_count read 0 immediately; the next instruction shows no forwarding.

Source files
------------

// File: rtl/forward_ctrl.sv
// Operand forwarding and load-use stall control for a 5-stage pipeline.
// Optional stall counter: define FWD_PERF_CNT_EN to add the stall_count port.
module forward_ctrl #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             a_sel1,
  output logic             a_sel0,
  output logic             b_sel1,
  output logic             b_sel0,
  output logic             stall
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_count
`endif
);

  localparam logic [REG_W-1:0] ZERO_RD = REG_W'(ZERO_REG);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } entry_t;

  entry_t ex_q;
  entry_t mem_q;

  // An entry produces src when it is a live writer of a non-zero register.
  function automatic logic hit(input entry_t e, input logic [REG_W-1:0] src);
    return e.valid && e.regwrite && (e.rd == src) && (e.rd != ZERO_RD);
  endfunction

  logic a_ex, a_mem, b_ex, b_mem;

  always_comb begin
    a_ex   = 1'b0;
    a_mem  = 1'b0;
    b_ex   = 1'b0;
    b_mem  = 1'b0;
    a_sel1 = 1'b0;
    a_sel0 = 1'b0;
    b_sel1 = 1'b0;
    b_sel0 = 1'b0;
    stall  = 1'b0;
    if (!reset && id_valid) begin
      a_ex   = hit(ex_q, id_rn);
      a_mem  = hit(mem_q, id_rn);
      b_ex   = hit(ex_q, id_rm);
      b_mem  = hit(mem_q, id_rm);
      // EX is the youngest producer, so it wins over MEM.
      a_sel1 = a_ex | a_mem;
      a_sel0 = a_ex;
      b_sel1 = b_ex | b_mem;
      b_sel0 = b_ex;
      stall  = !flush && ex_q.memread && (a_ex || b_ex);
    end
  end

  // Tracking pipeline: a stalled or flushed decode slot enters EX as a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      if (!stall && id_valid && !flush) begin
        ex_q.valid    <= 1'b1;
        ex_q.rd       <= id_rd;
        ex_q.regwrite <= id_regwrite;
        ex_q.memread  <= id_memread;
      end else begin
        ex_q <= '0;
      end
      mem_q <= ex_q;
    end
  end

`ifdef FWD_PERF_CNT_EN
  // Saturating count of stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 32'd0;
    end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl: history-based reference model checked every
// cycle, plus literal expectations for the key forwarding/stall scenarios.
module tb_forward_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rn, id_rm, id_rd;
  logic       id_regwrite, id_memread, flush;
  logic       a_sel1, a_sel0, b_sel1, b_sel0, stall;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  forward_ctrl #(.REG_W(5), .ZERO_REG(31)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .a_sel1      (a_sel1),
    .a_sel0      (a_sel0),
    .b_sel1      (b_sel1),
    .b_sel0      (b_sel0),
    .stall       (stall)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the instructions that entered the pipeline, youngest first.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } ent_t;

  ent_t        hist[2];
  logic [31:0] cnt_exp = 32'd0;

  // {use_forward, from_ex} for the nearest older writer of src.
  function automatic logic [1:0] fwd_exp(input logic [4:0] src);
    if (reset || !id_valid || src == 5'd31) return 2'b00;
    for (int d = 0; d < 2; d++)
      if (hist[d].v && hist[d].rw && hist[d].rd == src)
        return (d == 0) ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic stall_exp();
    if (reset || !id_valid || flush) return 1'b0;
    return hist[0].v && hist[0].mr && hist[0].rw && hist[0].rd != 5'd31 &&
           (hist[0].rd == id_rn || hist[0].rd == id_rm);
  endfunction

  always @(posedge clk) begin : model
    logic s;
    s = stall_exp();
    if (reset) begin
      hist[0] = '{1'b0, 5'd0, 1'b0, 1'b0};
      hist[1] = '{1'b0, 5'd0, 1'b0, 1'b0};
      cnt_exp = 32'd0;
    end else begin
      if (s && cnt_exp != 32'hFFFF_FFFF) cnt_exp = cnt_exp + 32'd1;
      hist[1] = hist[0];
      if (id_valid && !flush && !s) hist[0] = '{1'b1, id_rd, id_regwrite, id_memread};
      else                          hist[0] = '{1'b0, 5'd0, 1'b0, 1'b0};
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [1:0] fa, fb;
    fa = fwd_exp(id_rn);
    fb = fwd_exp(id_rm);
    chk("model_a_sel1", 32'(a_sel1), 32'(fa[1]));
    chk("model_a_sel0", 32'(a_sel0), 32'(fa[0]));
    chk("model_b_sel1", 32'(b_sel1), 32'(fb[1]));
    chk("model_b_sel0", 32'(b_sel0), 32'(fb[0]));
    chk("model_stall",  32'(stall),  32'(stall_exp()));
`ifdef FWD_PERF_CNT_EN
    chk("model_stall_count", stall_count, cnt_exp);
`endif
  end

  // Present one decode slot for a cycle, then settle past the falling edge.
  task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic fl);
    @(posedge clk);
    #1;
    id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
    id_regwrite = rw; id_memread = mr; flush = fl;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_sel(input string name, input logic [4:0] exp);
    chk({name, "_a_sel1"}, 32'(a_sel1), 32'(exp[4]));
    chk({name, "_a_sel0"}, 32'(a_sel0), 32'(exp[3]));
    chk({name, "_b_sel1"}, 32'(b_sel1), 32'(exp[2]));
    chk({name, "_b_sel0"}, 32'(b_sel0), 32'(exp[1]));
    chk({name, "_stall"},  32'(stall),  32'(exp[0]));
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 1'b1; id_rn = 5'd3; id_rm = 5'd3; id_rd = 5'd3;
    id_regwrite = 1'b1; id_memread = 1'b1; flush = 1'b0;
    @(negedge clk);
    #1;
    chk_sel("reset", 5'b00000);
`ifdef FWD_PERF_CNT_EN
    chk("reset_count", stall_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    id_valid = 1'b0;

    // ADD X1 then SUB rn=1 rm=2: EX forward on A only.
    drive(1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0);
    chk_sel("ex_fwd", 5'b11000);
    idle();
    chk_sel("idle", 5'b00000);
    idle();

    // ADD X3, NOP, ORR rm=3: MEM forward on B.
    drive(1'b1, 5'd2, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    idle();
    drive(1'b1, 5'd7, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);
    chk_sel("mem_fwd", 5'b00100);

    // LDUR X5 then ADD rn=5: one stall cycle, then MEM forward.
    drive(1'b1, 5'd9, 5'd9, 5'd5, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd5, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0);
    chk_sel("load_use", 5'b11001);
    drive(1'b1, 5'd5, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0);
    chk_sel("load_use_held", 5'b10000);
`ifdef FWD_PERF_CNT_EN
    chk("load_use_count", stall_count, 32'd1);
`endif
    idle();
    idle();

    // X31 is never forwarded and never stalls.
    drive(1'b1, 5'd1, 5'd2, 5'd31, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd31, 5'd31, 5'd12, 1'b1, 1'b0, 1'b0);
    chk_sel("zero_reg", 5'b00000);
    drive(1'b1, 5'd1, 5'd2, 5'd31, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd31, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
    chk_sel("zero_load", 5'b00000);
    idle();
    idle();

    // ADD X4, ADD X4, consumer rn=4: EX wins.
    drive(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd13, 5'd14, 5'd4, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd4, 5'd15, 5'd16, 1'b1, 1'b0, 1'b0);
    chk_sel("ex_priority", 5'b11000);

    // Load-use with flush: no stall, then the next use forwards from MEM.
    drive(1'b1, 5'd9, 5'd9, 5'd5, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd5, 5'd0, 5'd17, 1'b1, 1'b0, 1'b1);
    chk_sel("flush_wins", 5'b11000);
    drive(1'b1, 5'd5, 5'd0, 5'd17, 1'b1, 1'b0, 1'b0);
    chk_sel("after_flush", 5'b10000);

    // Both operands from the same producer.
    drive(1'b1, 5'd1, 5'd2, 5'd20, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd20, 5'd20, 5'd21, 1'b1, 1'b0, 1'b0);
    chk_sel("same_prod", 5'b11110);
    idle();
    idle();

    // Reset asserted mid-stall drops everything at once.
    drive(1'b1, 5'd9, 5'd9, 5'd7, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd7, 5'd7, 5'd22, 1'b1, 1'b0, 1'b0);
    chk_sel("pre_reset", 5'b11111);
    reset = 1'b1;
    #1;
    chk_sel("mid_reset", 5'b00000);
`ifdef FWD_PERF_CNT_EN
    chk("mid_reset_count", stall_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    id_valid = 1'b0;
    drive(1'b1, 5'd7, 5'd7, 5'd22, 1'b1, 1'b0, 1'b0);
    chk_sel("post_reset", 5'b00000);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
